// File: rtl/accum_lanes.sv
// accum_lanes: multi-lane signed vector accumulator with valid/ready input and 2-deep result FIFO
module accum_lanes #(
  parameter int DATAW  = 19,
  parameter int ACCUMW = 32,
  parameter int LANES  = 4,
  parameter int SAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATAW-1:0]  data,
  input  logic                    ivalid,
  input  logic                    first,
  input  logic                    last,
  output logic                    iready,
  output logic [LANES*ACCUMW-1:0] result,
  output logic [LANES-1:0]        overflow,
  output logic                    ovalid,
  input  logic                    oready
);
  localparam logic [ACCUMW-1:0] MAXV = {1'b0, {(ACCUMW-1){1'b1}}};
  localparam logic [ACCUMW-1:0] MINV = {1'b1, {(ACCUMW-1){1'b0}}};
  logic [ACCUMW-1:0] sum_q [LANES];
  logic [ACCUMW-1:0] sum_d [LANES];
  logic [ACCUMW-1:0] nsum [LANES];
  logic [ACCUMW-1:0] dx [LANES];
  logic [ACCUMW-1:0] base [LANES];
  logic [ACCUMW:0]   s [LANES];
  logic [LANES-1:0]  ovf, nstk, stk_q, stk_d;
  logic [LANES*ACCUMW-1:0] new_res, hd_res_q, hd_res_d, tl_res_q, tl_res_d;
  logic [LANES-1:0]  hd_ovf_q, hd_ovf_d, tl_ovf_q, tl_ovf_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rdy_q, accept, push, pop, hd_new;
  assign iready   = rdy_q && cnt_q != 2'd2;
  assign ovalid   = cnt_q != 2'd0;
  assign result   = hd_res_q;
  assign overflow = hd_ovf_q;
  always_comb begin
    accept  = ivalid && iready;
    push    = accept && last;
    pop     = ovalid && oready;
    new_res = '0;
    nstk    = '0;
    ovf     = '0;
    for (int i = 0; i < LANES; i++) begin
      dx[i]    = ACCUMW'($signed(data[i*DATAW +: DATAW]));
      base[i]  = first ? '0 : sum_q[i];
      s[i]     = {base[i][ACCUMW-1], base[i]} + {dx[i][ACCUMW-1], dx[i]};
      ovf[i]   = s[i][ACCUMW] ^ s[i][ACCUMW-1];
      nsum[i]  = (ovf[i] && SAT != 0) ? (s[i][ACCUMW] ? MINV : MAXV) : s[i][ACCUMW-1:0];
      nstk[i]  = (!first && stk_q[i]) || ovf[i];
      new_res[i*ACCUMW +: ACCUMW] = nsum[i];
      sum_d[i] = accept ? nsum[i] : sum_q[i];
    end
    stk_d    = accept ? nstk : stk_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    // a push lands in the head when the FIFO is empty or its only entry leaves this cycle
    hd_new   = push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop));
    hd_res_d = hd_new ? new_res : (pop && cnt_q == 2'd2) ? tl_res_q : hd_res_q;
    hd_ovf_d = hd_new ? nstk : (pop && cnt_q == 2'd2) ? tl_ovf_q : hd_ovf_q;
    tl_res_d = (push && cnt_q == 2'd1 && !pop) ? new_res : tl_res_q;
    tl_ovf_d = (push && cnt_q == 2'd1 && !pop) ? nstk : tl_ovf_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q    <= '{default: '0};
      stk_q    <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      hd_res_q <= '0;
      hd_ovf_q <= '0;
      tl_res_q <= '0;
      tl_ovf_q <= '0;
    end else begin
      sum_q    <= sum_d;
      stk_q    <= stk_d;
      cnt_q    <= cnt_d;
      rdy_q    <= 1'b1;
      hd_res_q <= hd_res_d;
      hd_ovf_q <= hd_ovf_d;
      tl_res_q <= tl_res_d;
      tl_ovf_q <= tl_ovf_d;
    end
  end
endmodule

// File: tb/tb_accum_lanes.sv
// tb_accum_lanes: checks three accum_lanes configurations against an integer-arithmetic vector model
module tb_accum_lanes;
  logic         clk, rst, ivalid, first, last, oready;
  logic [75:0]  data;
  logic         ira, irs, irw, ova, ovs, ovw;
  logic [127:0] ra;
  logic [79:0]  rs, rw;
  logic [3:0]   oa, os, ow;
  int checks = 0;
  int errors = 0;

  accum_lanes ua (.clk(clk), .rst(rst), .data(data), .ivalid(ivalid), .first(first), .last(last),
    .iready(ira), .result(ra), .overflow(oa), .ovalid(ova), .oready(oready));
  accum_lanes #(.ACCUMW(20), .SAT(1)) us (.clk(clk), .rst(rst), .data(data), .ivalid(ivalid),
    .first(first), .last(last), .iready(irs), .result(rs), .overflow(os), .ovalid(ovs), .oready(oready));
  accum_lanes #(.ACCUMW(20), .SAT(0)) uw (.clk(clk), .rst(rst), .data(data), .ivalid(ivalid),
    .first(first), .last(last), .iready(irw), .result(rw), .overflow(ow), .ovalid(ovw), .oready(oready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] a;
    logic [79:0]  s;
    logic [79:0]  w;
    logic [3:0]   oa, os, ow;
  } ent_t;

  ent_t   q[$];
  longint sm [3][4];
  bit     sk [3][4];
  bit     rdy_m;
  int     wd [3] = '{32, 20, 20};
  bit     st [3] = '{1'b1, 1'b1, 1'b0};

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint fit(longint v, int w, bit sat, output bit o);
    longint lo, hi, m, r;
    lo = -(longint'(1) <<< (w - 1));
    hi = (longint'(1) <<< (w - 1)) - 1;
    m  = longint'(1) <<< w;
    o  = (v < lo) || (v > hi);
    if (!o) return v;
    if (sat) return (v < lo) ? lo : hi;
    r = (v - lo) % m;
    if (r < 0) r += m;
    return r + lo;
  endfunction

  function automatic logic [75:0] pk(int a, int b, int c, int d);
    return {19'(d), 19'(c), 19'(b), 19'(a)};
  endfunction

  function automatic logic [18:0] rnd19();
    case ($urandom_range(0, 3))
      0: return 19'h3FFFF;
      1: return 19'h40000;
      default: return 19'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 4; i++) begin
        sm[c][i] = 0;
        sk[c][i] = 1'b0;
      end
    q.delete();
    rdy_m = 1'b0;
  endtask

  task automatic check_all();
    bit ne;
    ne = q.size() != 0;
    chk("iready_a", ira, rdy_m && q.size() < 2);
    chk("iready_s", irs, rdy_m && q.size() < 2);
    chk("iready_w", irw, rdy_m && q.size() < 2);
    chk("ovalid_a", ova, ne);
    chk("ovalid_s", ovs, ne);
    chk("ovalid_w", ovw, ne);
    if (ne) begin
      chk("result_a", ra, q[0].a);
      chk("result_s", rs, q[0].s);
      chk("result_w", rw, q[0].w);
      chk("ovf_a", oa, q[0].oa);
      chk("ovf_s", os, q[0].os);
      chk("ovf_w", ow, q[0].ow);
    end
  endtask

  task automatic step(bit v, bit f, bit l, logic [75:0] dv, bit ordy);
    bit acc, pp, o;
    ent_t e;
    logic signed [18:0] x;
    longint b, t;
    ivalid = v; first = f; last = l; data = dv; oready = ordy;
    acc = v && rdy_m && q.size() < 2;
    pp  = ordy && q.size() != 0;
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) begin
      e = '0;
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 4; i++) begin
          x = dv[i*19 +: 19];
          b = f ? 0 : sm[c][i];
          sm[c][i] = fit(b + longint'(x), wd[c], st[c], o);
          sk[c][i] = (!f && sk[c][i]) || o;
        end
      for (int i = 0; i < 4; i++) begin
        t = sm[0][i]; e.a[i*32 +: 32] = t[31:0];
        t = sm[1][i]; e.s[i*20 +: 20] = t[19:0];
        t = sm[2][i]; e.w[i*20 +: 20] = t[19:0];
        e.oa[i] = sk[0][i];
        e.os[i] = sk[1][i];
        e.ow[i] = sk[2][i];
      end
      if (l) q.push_back(e);
    end
    rdy_m = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; ivalid = 1'b0; first = 1'b0; last = 1'b0; oready = 1'b0; data = '0;
    model_reset();
    @(negedge clk);
    chk("rst_result_a", ra, 128'd0);
    chk("rst_ovf_a", oa, 4'd0);
    check_all();
    rst = 1'b0;
    #1 check_all();
    step(0, 0, 0, '0, 1);
    // three-beat vector across all lanes
    step(1, 1, 0, pk(1, 2, 3, 4), 1);
    step(1, 0, 0, pk(10, 20, 30, 40), 1);
    step(1, 0, 1, pk(-5, -5, -5, -5), 1);
    chk("t1_result", ra, {32'd39, 32'd28, 32'd17, 32'd6});
    chk("t1_ovf", oa, 4'b0000);
    step(0, 0, 0, '0, 1);
    // single-beat vector at the most negative input
    step(1, 1, 1, pk(-262144, 0, 0, 0), 1);
    chk("t2_lane0", ra[31:0], 32'hFFFC0000);
    step(0, 0, 0, '0, 1);
    // backpressure: third vector waits until a slot frees
    step(1, 1, 1, pk(1, 0, 0, 0), 0);
    step(1, 1, 1, pk(2, 0, 0, 0), 0);
    step(1, 1, 1, pk(3, 0, 0, 0), 0);
    chk("t3_full_iready", ira, 1'b0);
    chk("t3_head1", ra[31:0], 32'd1);
    step(1, 1, 1, pk(3, 0, 0, 0), 1);
    chk("t3_head2", ra[31:0], 32'd2);
    step(1, 1, 1, pk(3, 0, 0, 0), 1);
    chk("t3_head3", ra[31:0], 32'd3);
    step(0, 0, 0, '0, 1);
    // saturate vs wrap on the 20-bit variants
    step(1, 1, 0, pk(262143, 0, 0, 0), 1);
    step(1, 0, 0, pk(262143, 0, 0, 0), 1);
    step(1, 0, 1, pk(262143, 0, 0, 0), 1);
    chk("t4_sat", rs, 80'd524287);
    chk("t4_sat_ovf", os, 4'b0001);
    chk("t4_wrap", rw, {60'd0, 20'hBFFFD});
    chk("t4_wrap_ovf", ow, 4'b0001);
    chk("t4_wide", ra[31:0], 32'd786429);
    step(1, 1, 1, pk(5, 0, 0, 0), 1);
    chk("t4_next_sat", rs[19:0], 20'd5);
    chk("t4_next_ovf", os, 4'b0000);
    // restart mid-vector discards the partial sum
    step(1, 1, 0, pk(100, 100, 100, 100), 1);
    step(1, 0, 0, pk(200, 200, 200, 200), 1);
    step(1, 1, 0, pk(7, 7, 7, 7), 1);
    step(1, 0, 1, pk(8, 8, 8, 8), 1);
    chk("t5_restart", ra[31:0], 32'd15);
    step(0, 0, 0, '0, 1);
    // asynchronous reset with a pending entry and a partial sum
    step(1, 1, 1, pk(9, 9, 9, 9), 0);
    step(1, 1, 0, pk(50, 50, 50, 50), 0);
    ivalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_ovalid_drop", ova, 1'b0);
    chk("t6_iready_drop", ira, 1'b0);
    chk("t6_result_clr", ra, 128'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_all();
    step(0, 0, 0, '0, 1);
    step(1, 1, 0, pk(3, 0, 0, 0), 1);
    step(1, 0, 1, pk(4, 0, 0, 0), 1);
    chk("t6_after", ra[31:0], 32'd7);
    // randomized traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           {rnd19(), rnd19(), rnd19(), rnd19()}, $urandom_range(0, 3) != 0);
    for (int n = 0; n < 3; n++) step(0, 0, 0, '0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
